user_div: RTL and testbench
===========================

// Module: user_div
// PURPOSE
//   Free-running sequential unsigned integer divider (restoring, one quotient bit per clock).
//   Continuously samples dividend/divisor, computes floor(dividend/divisor), publishes the
//   quotient with a one-cycle done_sig pulse, then immediately restarts on the current inputs.
//   No start handshake: consumers hold operands stable and take quotient on done_sig.
// PARAMETERS
//   WIDTH  20  operand/quotient bit width (dividend, divisor, quotient)
// PORTS
//   clk       in   1      rising-edge clock; single clock domain
//   rst_n     in   1      asynchronous active-low reset
//   dividend  in   WIDTH  unsigned dividend, sampled in LOAD
//   divisor   in   WIDTH  unsigned divisor, sampled in LOAD
//   quotient  out  WIDTH  registered result of last completed division
//   done_sig  out  1      registered; high exactly one cycle when quotient updates
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset (rst_n=0, async): state=LOAD, quotient=0, done_sig=0, internal regs/counter=0.
//   FSM, 3 states:
//   - LOAD (1 cycle): latch dividend->q_reg, divisor->d_reg, rem=0, cnt=0 -> CALC.
//   - CALC (WIDTH cycles): {rem,q_reg} <<= 1; if rem_shifted >= d_reg: rem -= d_reg, q_reg[0]=1,
//     else q_reg[0]=0; cnt++; after WIDTH-th iteration -> DONE. rem is WIDTH+1 bits.
//   - DONE (1 cycle): quotient <= q_reg and done_sig <= 1 on the edge entering DONE-exit;
//     -> LOAD. done_sig cleared on the following edge.
//   Timing: one result every WIDTH+2 = 22 cycles. First done_sig high in cycle 22 after reset
//     release (cycles counted from first rising edge with rst_n=1); quotient valid same cycle
//     and held stable until next done_sig.
//   Operands: only values present at the LOAD edge matter; changes during CALC/DONE are ignored
//     and picked up by the next LOAD.
//   Divide by zero: restoring algorithm naturally yields quotient = all ones (0xFFFFF);
//     required behaviour; done_sig pulses normally.
//   dividend < divisor -> quotient 0. divisor=1 -> quotient=dividend.
//   Reset mid-operation: abort immediately, outputs to reset values, restart with LOAD.
//   No X propagation: all regs reset; outputs never undefined after reset.
//   Unsigned arithmetic only; no remainder output.
// TESTING
//   1. rst_n low 3 cycles, release; dividend=10, divisor=3 -> done_sig pulse at cycle 22,
//      quotient=3; pulses repeat every 22 cycles with quotient=3.
//   2. dividend=0xFFFFF, divisor=1 -> quotient=0xFFFFF; dividend=1000, divisor=7 -> 142.
//   3. dividend=5, divisor=9 -> quotient=0; dividend=0, divisor=4 -> 0.
//   4. divisor=0, dividend=123 -> quotient=0xFFFFF, done_sig still pulses.
//   5. change dividend 10->100 (divisor 3) mid-CALC -> next pulse quotient=3, following 33.
//   6. assert rst_n mid-CALC -> quotient=0, done_sig=0 immediately; next result 22 cycles
//      after release; done_sig never high two consecutive cycles.

Source files
------------

// File: rtl/user_div_if.sv
// Operand/result bundle for the free-running divider.
// The consumer (master) drives the operands and takes the quotient on done_sig.
// The divider (slave) samples the operands and publishes the result.
interface user_div_if #(
  parameter int WIDTH = 20
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic             done_sig;

  modport master (
    output dividend,
    output divisor,
    input  quotient,
    input  done_sig
  );

  modport slave (
    input  dividend,
    input  divisor,
    output quotient,
    output done_sig
  );
endinterface

// File: rtl/user_div.sv
// Free-running restoring unsigned divider, one quotient bit per clock.
// It loads the operands, iterates WIDTH times, publishes the quotient with a
// one-cycle done_sig pulse and immediately starts over on the current inputs,
// so one result appears every WIDTH+2 cycles.
module user_div #(
  parameter int WIDTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  user_div_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] q_reg_q,    q_reg_d;
  logic [WIDTH-1:0] d_reg_q,    d_reg_d;
  logic [WIDTH:0]   rem_q,      rem_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             done_q,     done_d;

  // The partial remainder is shifted left with the next dividend bit pulled
  // in from the top of q_reg. It is kept two bits wider than the operands
  // so the comparison never wraps, even when the divisor is zero and the
  // remainder keeps growing without being reduced.
  logic [WIDTH+1:0] rem_shifted;
  logic [WIDTH+1:0] divisor_ext;
  logic             sub_ok;

  // Datapath helpers for the current CALC iteration
  always_comb begin
    rem_shifted = {rem_q, q_reg_q[WIDTH-1]};
    divisor_ext = {2'b00, d_reg_q};
    sub_ok      = (rem_shifted >= divisor_ext);
  end

  // Next-state and next-register computation for the LOAD/CALC/DONE loop
  always_comb begin
    state_d    = state_q;
    q_reg_d    = q_reg_q;
    d_reg_d    = d_reg_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    done_d     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // Only operands present on this edge matter for the coming result.
        q_reg_d = bus.dividend;
        d_reg_d = bus.divisor;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_CALC;
      end

      ST_CALC: begin
        // A zero divisor always subtracts, which produces an all-ones quotient.
        if (sub_ok) begin
          rem_d   = (WIDTH+1)'(rem_shifted - divisor_ext);
          q_reg_d = {q_reg_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d   = (WIDTH+1)'(rem_shifted);
          q_reg_d = {q_reg_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        quotient_d = q_reg_q;
        done_d     = 1'b1;
        state_d    = ST_LOAD;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      q_reg_q    <= '0;
      d_reg_q    <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_reg_q    <= q_reg_d;
      d_reg_q    <= d_reg_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      done_q     <= done_d;
    end
  end

  // Outputs come straight from registers so they never glitch
  always_comb begin
    bus.quotient = quotient_q;
    bus.done_sig = done_q;
  end

endmodule

// File: tb/tb_user_div.sv
// Self-checking bench for the free-running divider.
// A monitor counts cycles since reset release, pushes the expected quotient
// whenever the divider loads its operands and pops it when done_sig is due.
module tb_user_div;

  localparam int WIDTH  = 20;
  localparam int PERIOD = WIDTH + 2;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic clk;
  logic rst_n;

  user_div_if #(.WIDTH(WIDTH)) dif ();

  user_div #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  int checks_done;
  int errors_found;
  int cycle;
  int results_seen;
  logic [WIDTH-1:0] held_quotient;
  logic [WIDTH-1:0] sb_q[$];

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_done++;
    if (observed !== expected) begin
      errors_found++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Reference division: a zero divisor yields all ones
  function automatic logic [WIDTH-1:0] refDiv(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    if (b == '0) return ALL_ONES;
    return a / b;
  endfunction

  // Drive a new operand pair on a falling edge, away from the sampling edge
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the cycle counter reaches a given phase of the 22-cycle loop
  task automatic waitPhase(input int phase);
    int guard;
    guard = 0;
    while ((cycle % PERIOD) != phase && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("phase_reached", 32'(cycle % PERIOD), 32'(phase));
  endtask

  // Scoreboard monitor: load edges are cycles 1, 23, 45...; done is due on
  // cycles 22, 44, 66... and must be low on every other cycle
  initial begin
    cycle         = 0;
    results_seen  = 0;
    held_quotient = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cycle         = 0;
        held_quotient = '0;
        sb_q.delete();
      end else begin
        cycle++;
        if (((cycle - 1) % PERIOD) == 0) begin
          sb_q.push_back(refDiv(dif.dividend, dif.divisor));
        end
        #1;
        if ((cycle % PERIOD) == 0) begin
          checkOutput("done_pulse", 32'(dif.done_sig), 32'd1);
          if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd1);
          end else begin
            held_quotient = sb_q.pop_front();
            results_seen++;
          end
        end else begin
          checkOutput("done_idle", 32'(dif.done_sig), 32'd0);
        end
        checkOutput("quotient", 32'(dif.quotient), 32'(held_quotient));
      end
    end
  end

  // Directed scenarios followed by a few random operand pairs
  initial begin
    checks_done  = 0;
    errors_found = 0;
    rst_n        = 1'b0;
    dif.dividend = 20'd10;
    dif.divisor  = 20'd3;

    // Reset state
    waitCycles(3);
    #1;
    checkOutput("reset_quotient", 32'(dif.quotient), 32'd0);
    checkOutput("reset_done", 32'(dif.done_sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10/3 repeats every 22 cycles
    waitCycles(3 * PERIOD + 4);

    // Boundary operands
    applyStimulus(ALL_ONES, 20'd1);
    waitCycles(2 * PERIOD);
    applyStimulus(20'd1000, 20'd7);
    waitCycles(2 * PERIOD);
    applyStimulus(20'd5, 20'd9);
    waitCycles(2 * PERIOD);
    applyStimulus(20'd0, 20'd4);
    waitCycles(2 * PERIOD);
    applyStimulus(20'd123, 20'd0);
    waitCycles(2 * PERIOD);

    // Operand change in the middle of CALC only affects the following result
    applyStimulus(20'd10, 20'd3);
    waitCycles(2 * PERIOD);
    waitPhase(10);
    dif.dividend = 20'd100;
    waitCycles(2 * PERIOD + 6);

    // Reset in the middle of CALC clears the outputs immediately
    waitPhase(8);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_quotient", 32'(dif.quotient), 32'd0);
    checkOutput("midreset_done", 32'(dif.done_sig), 32'd0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2 * PERIOD + 4);

    // Random operand pairs held for a full loop each
    for (int i = 0; i < 6; i++) begin
      applyStimulus(20'($urandom_range(0, 20'hFFFFF)), 20'($urandom_range(1, 5000)));
      waitCycles(PERIOD + 1);
    end
    waitCycles(2 * PERIOD);

    checkOutput("result_count_ok", 32'(results_seen >= 20), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks_done, errors_found);
    $finish;
  end

endmodule
